// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//
// Parametrised pipeline stage register with a valid/ready handshake, hold,
// flush, optional two-entry skid buffer and a saturating stall counter. All
// control and operand fields of a stage travel as one packed payload word.
//
// Parameters
//   DATA_W     width of the packed stage payload
//   SKID       1 = two-entry skid buffer, in_ready independent of out_ready
//              0 = single register, in_ready depends combinationally on out_ready
//   CNT_W      stall counter width
//
// Ports
//   clk        stage clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   flush      kill all stage contents (valid bits only, data is kept)
//   hold       freeze stage: no accept, no emit
//   in_valid   upstream payload valid
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  payload presented downstream
//   out_ready  downstream accepts
//   out_data   payload to next stage (main register)
//   occupancy  entries held: 0, 1 or 2 (2 only with SKID=1)
//   stall_cnt  saturating count of cycles with a valid payload not leaving
// -----------------------------------------------------------------------------
module pipe_stage #(
   parameter int DATA_W = 64,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // State encoding doubles as the occupancy count; main_valid and skid_valid
   // are decoded from it so the two valid bits can never disagree.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_main_data;
   logic [DATA_W-1:0]   w_skid_data;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_main_valid;
   logic                w_skid_valid;
   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_load_main_in;
   logic                w_load_main_skid;
   logic                w_load_skid;

   assign w_main_valid = (r_state != ST_EMPTY);
   assign w_skid_valid = (r_state == ST_FULL);
   assign w_out_valid  = w_main_valid & ~hold;
   assign w_in_fire    = in_valid & w_in_ready;
   assign w_out_fire   = w_out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic [DATA_W-1:0] r_skid_data;

         // Ready only looks at local state, so there is no combinational
         // path from out_ready back to in_ready; the skid entry absorbs the
         // one payload that is in flight when back-pressure starts.
         assign w_in_ready = ~w_skid_valid & ~hold & ~flush;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_skid_data <= '0;
            end else if (w_load_skid) begin
               r_skid_data <= in_data;
            end
         end

         assign w_skid_data = r_skid_data;
      end else begin : g_noskid
         assign w_in_ready  = ~hold & ~flush & (~w_main_valid | out_ready);
         assign w_skid_data = '0;
      end
   endgenerate

   // Next state and data-load strobes. Hold needs no branch of its own: it
   // forces in_ready and out_valid low, so neither handshake can fire.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, otherwise a
      // path that skips the assignment would infer a latch.
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;

      if (flush) begin
         // Only the valid state is cleared; data registers keep their values.
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt    = ST_ONE;
                  w_load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_main_in = 1'b1;
               end else if (w_in_fire && (SKID != 0)) begin
                  w_state_nxt = ST_FULL;
                  w_load_skid = 1'b1;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_state_nxt      = ST_ONE;
                  w_load_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_data <= '0;
      end else if (w_load_main_in) begin
         r_main_data <= in_data;
      end else if (w_load_main_skid) begin
         r_main_data <= w_skid_data;
      end
   end

   // Counts hold and back-pressure cycles alike; saturates instead of
   // wrapping and is cleared only by reset, never by flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_main_valid && !w_out_fire && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = r_main_data;
   assign occupancy = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
//
// Drives two pipe_stage instances from shared inputs: u_skid (SKID=1, CNT_W=4)
// and u_noskid (SKID=0, CNT_W=16). Each vector describes one clock cycle: the
// inputs applied during the cycle and the outputs expected before the edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

   localparam int DW = 8;

   typedef struct {
      logic          flush;
      logic          hold;
      logic          in_valid;
      logic [DW-1:0] in_data;
      logic          out_ready;
      logic          exp_ir;
      logic          exp_ov;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_occ;
      int            exp_stall;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          hold;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_ready;

   logic          a_in_ready, a_out_valid;
   logic [DW-1:0] a_out_data;
   logic [1:0]    a_occ;
   logic [3:0]    a_stall;

   logic          b_in_ready, b_out_valid;
   logic [DW-1:0] b_out_data;
   logic [1:0]    b_occ;
   logic [15:0]   b_stall;

   int n_checks = 0;
   int n_errors = 0;

   vec_t vec_a[$];
   vec_t vec_b[$];

   always #5 clk = ~clk;

   pipe_stage #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic fl, input logic ho, input logic iv,
                               input logic [DW-1:0] d, input logic ordy,
                               input logic eir, input logic eov,
                               input logic [DW-1:0] ed, input logic [1:0] eocc,
                               input int est);
      vec_t v;
      v.flush = fl;  v.hold = ho;  v.in_valid = iv;  v.in_data = d;
      v.out_ready = ordy;  v.exp_ir = eir;  v.exp_ov = eov;
      v.exp_data = ed;  v.exp_occ = eocc;  v.exp_stall = est;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag, input int idx, input bit use_b);
      logic          ir, ov;
      logic [DW-1:0] dat;
      logic [1:0]    occ;
      logic [31:0]   st;
      flush     = v.flush;
      hold      = v.hold;
      in_valid  = v.in_valid;
      in_data   = v.in_data;
      out_ready = v.out_ready;
      #1;
      if (use_b) begin
         ir = b_in_ready; ov = b_out_valid; dat = b_out_data; occ = b_occ; st = 32'(b_stall);
      end else begin
         ir = a_in_ready; ov = a_out_valid; dat = a_out_data; occ = a_occ; st = 32'(a_stall);
      end
      check($sformatf("%s[%0d] in_ready", tag, idx), 32'(ir), 32'(v.exp_ir));
      check($sformatf("%s[%0d] out_valid", tag, idx), 32'(ov), 32'(v.exp_ov));
      if (v.exp_ov)
         check($sformatf("%s[%0d] out_data", tag, idx), 32'(dat), 32'(v.exp_data));
      check($sformatf("%s[%0d] occupancy", tag, idx), 32'(occ), 32'(v.exp_occ));
      check($sformatf("%s[%0d] stall_cnt", tag, idx), st, 32'(v.exp_stall));
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- SKID=1 vectors ----------------
      // Streaming 0x11..0x18 with out_ready high: one-cycle latency, no stalls.
      for (int k = 0; k < 8; k++)
         vec_a.push_back(mk(0, 0, 1, DW'(8'h11 + k), 1,
                            1, (k > 0), DW'(8'h10 + k), (k > 0) ? 2'd1 : 2'd0, 0));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h18, 1, 0));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
      // Back-pressure: skid absorbs 0xA2, 0xA3 waits upstream.
      vec_a.push_back(mk(0, 0, 1, 8'hA1, 1, 1, 0, 8'h00, 0, 0));
      vec_a.push_back(mk(0, 0, 1, 8'hA2, 0, 1, 1, 8'hA1, 1, 0));
      vec_a.push_back(mk(0, 0, 1, 8'hA3, 0, 0, 1, 8'hA1, 2, 1));
      vec_a.push_back(mk(0, 0, 1, 8'hA3, 0, 0, 1, 8'hA1, 2, 2));
      vec_a.push_back(mk(0, 0, 1, 8'hA3, 1, 0, 1, 8'hA1, 2, 3));
      vec_a.push_back(mk(0, 0, 1, 8'hA3, 1, 1, 1, 8'hA2, 1, 3));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'hA3, 1, 3));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3));
      // Flush while FULL with 0xFF offered, then flush with input on empty.
      vec_a.push_back(mk(0, 0, 1, 8'hB1, 0, 1, 0, 8'h00, 0, 3));
      vec_a.push_back(mk(0, 0, 1, 8'hB2, 0, 1, 1, 8'hB1, 1, 3));
      vec_a.push_back(mk(1, 0, 1, 8'hFF, 0, 0, 1, 8'hB1, 2, 4));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 5));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 5));
      vec_a.push_back(mk(1, 0, 1, 8'h77, 1, 0, 0, 8'h00, 0, 5));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 5));
      // Hold 0x55 for three cycles while 0x66 is offered; release emits once.
      vec_a.push_back(mk(0, 0, 1, 8'h55, 1, 1, 0, 8'h00, 0, 5));
      vec_a.push_back(mk(0, 1, 1, 8'h66, 1, 0, 0, 8'h00, 1, 5));
      vec_a.push_back(mk(0, 1, 1, 8'h66, 1, 0, 0, 8'h00, 1, 6));
      vec_a.push_back(mk(0, 1, 1, 8'h66, 1, 0, 0, 8'h00, 1, 7));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h55, 1, 8));
      vec_a.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8));

      // ---------------- SKID=0 vectors ----------------
      // Continuous input, out_ready toggling: in_ready follows out_ready.
      vec_b.push_back(mk(0, 0, 1, 8'hC1, 1, 1, 0, 8'h00, 0, 0));
      vec_b.push_back(mk(0, 0, 1, 8'hC2, 1, 1, 1, 8'hC1, 1, 0));
      vec_b.push_back(mk(0, 0, 1, 8'hC3, 0, 0, 1, 8'hC2, 1, 0));
      vec_b.push_back(mk(0, 0, 1, 8'hC3, 1, 1, 1, 8'hC2, 1, 1));
      vec_b.push_back(mk(0, 0, 1, 8'hC4, 0, 0, 1, 8'hC3, 1, 1));
      vec_b.push_back(mk(0, 0, 1, 8'hC4, 1, 1, 1, 8'hC3, 1, 2));
      vec_b.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'hC4, 1, 2));
      vec_b.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 2));

      // ---------------- Reset state ----------------
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      check("reset out_valid", 32'(a_out_valid), 32'd0);
      check("reset out_data", 32'(a_out_data), 32'd0);
      check("reset occupancy", 32'(a_occ), 32'd0);
      check("reset stall_cnt", 32'(a_stall), 32'd0);
      check("reset in_ready skid", 32'(a_in_ready), 32'd1);
      check("reset in_ready noskid", 32'(b_in_ready), 32'd1);

      for (int i = 0; i < vec_a.size(); i++)
         run_vec(vec_a[i], "skid", i, 1'b0);

      // ---------------- Saturation (CNT_W=4) ----------------
      rst = 1'b1;
      cycle();
      rst = 1'b0; flush = 1'b0; hold = 1'b0;
      in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (i == 14) check("sat stall_cnt@14", 32'(a_stall), 32'd14);
         if (i == 15) check("sat stall_cnt@15", 32'(a_stall), 32'd15);
      end
      check("sat stall_cnt@20", 32'(a_stall), 32'd15);
      check("sat out_data held", 32'(a_out_data), 32'h3C);

      // ---------------- Reset mid-transfer ----------------
      // Handshake offered in the reset cycle must be lost.
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
      cycle();
      rst = 1'b0; in_valid = 1'b0; in_data = '0;
      #1;
      check("rst out_valid", 32'(a_out_valid), 32'd0);
      check("rst out_data", 32'(a_out_data), 32'd0);
      check("rst occupancy", 32'(a_occ), 32'd0);
      check("rst stall_cnt", 32'(a_stall), 32'd0);
      check("rst in_ready", 32'(a_in_ready), 32'd1);
      cycle();
      check("rst payload lost", 32'(a_occ), 32'd0);
      check("rst noskid occupancy", 32'(b_occ), 32'd0);

      for (int i = 0; i < vec_b.size(); i++)
         run_vec(vec_b[i], "noskid", i, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with valid/ready handshake, hold, flush and an optional two-entry skid buffer. It replaces the fixed-field stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). All control and operand fields of a stage travel as one packed `in_data` word. It adds bubble tracking, flush, back-pressure and a stall counter, which the plain hold-only stage registers do not provide.

## Interface
Parameters:
- `DATA_W`, 64: width of the packed stage payload (rd, operands, immediate, control bits).
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk`  in  1  stage clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill all stage contents (branch/exception redirect).
- `hold`  in  1  freeze stage; no accept, no emit (replaces `hold_flag`).
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  payload presented downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload to next stage.
- `occupancy`  out  2  entries held: 0, 1 or 2 (2 only when SKID=1).
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.

## Operation
Handshake definitions:
- `in_fire` = `in_valid & in_ready`.
- `out_fire` = `out_valid & out_ready`.
- `out_valid` = `main_valid & ~hold`.
- `out_data` = main register.

Priority, highest first: `rst`, `flush`, `hold`, handshakes.

Reset and flush:
- `rst`: all valid bits 0, main and skid data 0, `stall_cnt` 0.
- `flush`: main and skid valid bits cleared next edge; data registers keep their values. `in_ready` = 0 during flush, so nothing is accepted. `out_valid` may still be 1 in the flush cycle; downstream must ignore it on flush (a fire in that cycle is legal and not repeated).

Hold:
- `in_ready` = 0 and `out_valid` = 0.
- All registers unchanged; only `stall_cnt` may change.

SKID=1 state machine (from valid bits):
- EMPTY (occupancy 0):
  - `in_fire` → ONE, main ← in.
- ONE (occupancy 1):
  - `in_fire & out_fire` → ONE, main ← in.
  - `in_fire & ~out_fire` → FULL, skid ← in.
  - `~in_fire & out_fire` → EMPTY.
  - Otherwise stay.
- FULL (occupancy 2):
  - `out_fire` → ONE, main ← skid.
  - `in_ready` is 0 in FULL, so no input is taken.
- `in_ready` = `~skid_valid & ~hold & ~flush`. It has no combinational path from `out_ready`.

SKID=0:
- `in_ready` = `~hold & ~flush & (~main_valid | out_ready)`.
- `in_fire` loads main; otherwise `out_fire` clears main_valid.
- Skid logic is not generated.

Stall counter:
- Increments each cycle with `main_valid & ~out_fire` (covers hold and back-pressure).
- Saturates at all ones and does not wrap.
- Flush does not clear it; only `rst` does.

Ordering: payloads leave in acceptance order. None is duplicated or dropped except by flush.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `occupancy` 0, `stall_cnt` 0.
- `in_ready` out of reset: 1 once `rst` deasserts (with `hold`/`flush` low).
- Latency: payload accepted at edge N is on `out_data` with `out_valid` = 1 after edge N (cycle N+1).
- Throughput: 1 payload/cycle when `out_ready` is held high, in both SKID modes.
- SKID=1 back-pressure: `in_ready` falls one cycle after the stall begins; the skid absorbs the one in-flight payload.
- Simultaneous `flush` and `in_valid`: input not accepted; stage is empty next cycle.
- `rst` mid-transfer: same-edge clear; any in-flight handshake is lost.
- `hold` released: emission resumes the same cycle `hold` falls.

## Test plan
- Streaming: SKID=1, `out_ready` = 1, send 0x11..0x18 back-to-back → outputs 0x11..0x18 on consecutive cycles, 1-cycle latency, `stall_cnt` = 0.
- Back-pressure: send 0xA1, 0xA2, 0xA3, with `out_ready` = 0 from the cycle after 0xA1 is accepted → occupancy 2, `in_ready` = 0, 0xA3 held upstream; then `out_ready` = 1 → 0xA1, 0xA2, 0xA3 in order with no loss.
- Flush in FULL: occupancy 2 plus `flush` with `in_valid` = 1 (0xFF) → next cycle occupancy 0, `out_valid` 0, 0xFF never emitted.
- Hold: valid 0x55 in main, `hold` for 3 cycles → `out_valid` 0 and `in_ready` 0 during hold, `stall_cnt` +3; release → 0x55 emitted once.
- SKID=0 mode: `out_ready` toggling 1,0,1,0 with continuous input → `in_ready` tracks `out_ready` combinationally while full; outputs in order.
- Saturation and reset: CNT_W = 4, stall 20 cycles → `stall_cnt` = 15 and stays there; pulse `rst` → all outputs 0.
